// File: rtl/store_queue_if.sv
// Handshake bundle between the store queue and its surroundings: issue, address/data capture,
// commit to the data-memory port, flush, and load lookup.
interface store_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic [4:0]        issue_ptr;
    logic [4:0]        commit_ptr;
    logic              full;
    logic              empty;
    logic              st_addr_valid;
    logic [4:0]        st_addr_entry;
    logic [ADDR_W-1:0] st_addr;
    logic              st_data_valid;
    logic [4:0]        st_data_entry;
    logic [DATA_W-1:0] st_data;
    logic              head_ready;
    logic              commit_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              flush;
    logic              lw_req_valid;
    logic [4:0]        lw_entry;
    logic [ADDR_W-1:0] lw_addr;
    logic              lw_resp_valid;
    logic              lw_hit;
    logic              lw_stall;
    logic [DATA_W-1:0] lw_data;

    modport master (
        output issue_valid, st_addr_valid, st_addr_entry, st_addr,
        output st_data_valid, st_data_entry, st_data, commit_valid, flush,
        output lw_req_valid, lw_entry, lw_addr,
        input  issue_ptr, commit_ptr, full, empty, head_ready,
        input  mem_we, mem_addr, mem_data,
        input  lw_resp_valid, lw_hit, lw_stall, lw_data
    );

    modport slave (
        input  issue_valid, st_addr_valid, st_addr_entry, st_addr,
        input  st_data_valid, st_data_entry, st_data, commit_valid, flush,
        input  lw_req_valid, lw_entry, lw_addr,
        output issue_ptr, commit_ptr, full, empty, head_ready,
        output mem_we, mem_addr, mem_data,
        output lw_resp_valid, lw_hit, lw_stall, lw_data
    );
endinterface

// File: rtl/store_queue.sv
// 32-entry circular store queue: in-order allocate and retire, out-of-order address/data
// capture, and load forwarding restricted to stores older than the load.
module store_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic         clk,
    input logic         reset,
    store_queue_if.slave sq
);
    localparam int N = 32;

    logic [N-1:0]      v_q, v_d, av_q, av_d, dv_q, dv_d;
    logic [ADDR_W-1:0] addr_q [N];
    logic [ADDR_W-1:0] addr_d [N];
    logic [DATA_W-1:0] data_q [N];
    logic [DATA_W-1:0] data_d [N];
    logic [4:0]        issue_ptr_q, issue_ptr_d, commit_ptr_q, commit_ptr_d;
    logic [5:0]        count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              lw_resp_valid_q, lw_resp_valid_d;
    logic              lw_hit_q, lw_hit_d, lw_stall_q, lw_stall_d;
    logic [DATA_W-1:0] lw_data_q, lw_data_d;

    logic       full_s, empty_s, head_ready_s, commit_acc_s, issue_acc_s;
    logic       found_s, stall_any_s, all_older_s, lw_stall_s, lw_hit_s;
    logic [4:0] best_s, lw_dist_s, scan_idx_s;

    assign full_s       = (count_q == 6'd32);
    assign empty_s      = (count_q == 6'd0);
    assign head_ready_s = v_q[commit_ptr_q] & av_q[commit_ptr_q] & dv_q[commit_ptr_q];
    assign commit_acc_s = sq.commit_valid & head_ready_s & ~sq.flush;
    // A full queue can still take an issue when the head retires in the same cycle.
    assign issue_acc_s  = sq.issue_valid & (~full_s | commit_acc_s) & ~sq.flush;

    // Scan older entries from head to youngest; the last address match wins.
    always_comb begin
        found_s     = 1'b0;
        stall_any_s = 1'b0;
        best_s      = 5'd0;
        scan_idx_s  = 5'd0;
        lw_dist_s   = sq.lw_entry - commit_ptr_q;
        all_older_s = (sq.lw_entry == commit_ptr_q) & full_s;
        for (int k = 0; k < N; k++) begin
            scan_idx_s = commit_ptr_q + 5'(k);
            if (v_q[scan_idx_s] && (all_older_s || (5'(k) < lw_dist_s))) begin
                if (!av_q[scan_idx_s]) begin
                    stall_any_s = 1'b1;
                end else if (addr_q[scan_idx_s][ADDR_W-1:2] == sq.lw_addr[ADDR_W-1:2]) begin
                    found_s = 1'b1;
                    best_s  = scan_idx_s;
                end else begin
                    found_s = found_s;
                end
            end else begin
                found_s = found_s;
            end
        end
        lw_stall_s = stall_any_s | (found_s & ~dv_q[best_s]);
        lw_hit_s   = ~lw_stall_s & found_s;
    end

    // Next-state for entries, pointers and count.
    always_comb begin
        v_d          = v_q;
        av_d         = av_q;
        dv_d         = dv_q;
        addr_d       = addr_q;
        data_d       = data_q;
        issue_ptr_d  = issue_ptr_q;
        commit_ptr_d = commit_ptr_q;
        count_d      = count_q;
        if (sq.flush) begin
            v_d         = {N{1'b0}};
            issue_ptr_d = commit_ptr_q;
            count_d     = 6'd0;
        end else begin
            if (commit_acc_s) begin
                v_d[commit_ptr_q] = 1'b0;
                commit_ptr_d      = commit_ptr_q + 5'd1;
            end else begin
                commit_ptr_d = commit_ptr_q;
            end
            if (issue_acc_s) begin
                v_d[issue_ptr_q]  = 1'b1;
                av_d[issue_ptr_q] = 1'b0;
                dv_d[issue_ptr_q] = 1'b0;
                issue_ptr_d       = issue_ptr_q + 5'd1;
            end else begin
                issue_ptr_d = issue_ptr_q;
            end
            if (sq.st_addr_valid && v_q[sq.st_addr_entry] &&
                !(commit_acc_s && (sq.st_addr_entry == commit_ptr_q))) begin
                av_d[sq.st_addr_entry]   = 1'b1;
                addr_d[sq.st_addr_entry] = sq.st_addr;
            end else begin
                av_d = av_d;
            end
            if (sq.st_data_valid && v_q[sq.st_data_entry] &&
                !(commit_acc_s && (sq.st_data_entry == commit_ptr_q))) begin
                dv_d[sq.st_data_entry]   = 1'b1;
                data_d[sq.st_data_entry] = sq.st_data;
            end else begin
                dv_d = dv_d;
            end
            case ({issue_acc_s, commit_acc_s})
                2'b10:   count_d = count_q + 6'd1;
                2'b01:   count_d = count_q - 6'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state for the memory write port and the lookup response.
    always_comb begin
        mem_we_d   = commit_acc_s;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (commit_acc_s) begin
            mem_addr_d = addr_q[commit_ptr_q];
            mem_data_d = data_q[commit_ptr_q];
        end else begin
            mem_addr_d = mem_addr_q;
        end
        lw_data_d = lw_data_q;
        if (sq.flush) begin
            lw_resp_valid_d = 1'b0;
        end else begin
            lw_resp_valid_d = sq.lw_req_valid;
        end
        if (sq.lw_req_valid) begin
            lw_hit_d   = lw_hit_s;
            lw_stall_d = lw_stall_s;
            if (lw_hit_s) begin
                lw_data_d = data_q[best_s];
            end else begin
                lw_data_d = lw_data_q;
            end
        end else begin
            lw_hit_d   = 1'b0;
            lw_stall_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q             <= {N{1'b0}};
            av_q            <= {N{1'b0}};
            dv_q            <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                addr_q[i] <= {ADDR_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
            end
            issue_ptr_q     <= 5'd0;
            commit_ptr_q    <= 5'd0;
            count_q         <= 6'd0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= {ADDR_W{1'b0}};
            mem_data_q      <= {DATA_W{1'b0}};
            lw_resp_valid_q <= 1'b0;
            lw_hit_q        <= 1'b0;
            lw_stall_q      <= 1'b0;
            lw_data_q       <= {DATA_W{1'b0}};
        end else begin
            v_q             <= v_d;
            av_q            <= av_d;
            dv_q            <= dv_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            issue_ptr_q     <= issue_ptr_d;
            commit_ptr_q    <= commit_ptr_d;
            count_q         <= count_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            lw_resp_valid_q <= lw_resp_valid_d;
            lw_hit_q        <= lw_hit_d;
            lw_stall_q      <= lw_stall_d;
            lw_data_q       <= lw_data_d;
        end
    end

    assign sq.issue_ptr     = issue_ptr_q;
    assign sq.commit_ptr    = commit_ptr_q;
    assign sq.full          = full_s;
    assign sq.empty         = empty_s;
    assign sq.head_ready    = head_ready_s;
    assign sq.mem_we        = mem_we_q;
    assign sq.mem_addr      = mem_addr_q;
    assign sq.mem_data      = mem_data_q;
    assign sq.lw_resp_valid = lw_resp_valid_q;
    assign sq.lw_hit        = lw_hit_q;
    assign sq.lw_stall      = lw_stall_q;
    assign sq.lw_data       = lw_data_q;
endmodule

// File: tb/tb_store_queue.sv
// Directed test of store_queue: forwarding, stalls, wrap-around, full queue, commit and flush.
module tb_store_queue;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    store_queue_if #(.ADDR_W(AW), .DATA_W(DW)) sq_if ();
    store_queue #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .sq(sq_if));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        sq_if.issue_valid   = 1'b0;
        sq_if.st_addr_valid = 1'b0;
        sq_if.st_addr_entry = 5'd0;
        sq_if.st_addr       = 32'h0;
        sq_if.st_data_valid = 1'b0;
        sq_if.st_data_entry = 5'd0;
        sq_if.st_data       = 32'h0;
        sq_if.commit_valid  = 1'b0;
        sq_if.flush         = 1'b0;
        sq_if.lw_req_valid  = 1'b0;
        sq_if.lw_entry      = 5'd0;
        sq_if.lw_addr       = 32'h0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue_n(input int n);
        sq_if.issue_valid = 1'b1;
        repeat (n) tick();
        sq_if.issue_valid = 1'b0;
    endtask

    task automatic write_entry(input logic [4:0] e, input logic [31:0] a, input logic [31:0] d,
                               input logic wa, input logic wd);
        sq_if.st_addr_valid = wa;
        sq_if.st_addr_entry = e;
        sq_if.st_addr       = a;
        sq_if.st_data_valid = wd;
        sq_if.st_data_entry = e;
        sq_if.st_data       = d;
        tick();
        sq_if.st_addr_valid = 1'b0;
        sq_if.st_data_valid = 1'b0;
    endtask

    task automatic lookup(input logic [4:0] e, input logic [31:0] a);
        sq_if.lw_req_valid = 1'b1;
        sq_if.lw_entry     = e;
        sq_if.lw_addr      = a;
        tick();
        sq_if.lw_req_valid = 1'b0;
    endtask

    task automatic commit_one;
        sq_if.commit_valid = 1'b1;
        tick();
        sq_if.commit_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_issue_ptr", sq_if.issue_ptr, 64'd0);
        check_eq("rst_commit_ptr", sq_if.commit_ptr, 64'd0);
        check_eq("rst_empty", sq_if.empty, 64'd1);
        check_eq("rst_full", sq_if.full, 64'd0);
        check_eq("rst_mem_we", sq_if.mem_we, 64'd0);
        check_eq("rst_resp_valid", sq_if.lw_resp_valid, 64'd0);

        // Youngest-match forwarding
        issue_n(3);
        check_eq("t1_issue_ptr", sq_if.issue_ptr, 64'd3);
        write_entry(5'd0, 32'h100, 32'hA, 1'b1, 1'b1);
        write_entry(5'd1, 32'h200, 32'hB, 1'b1, 1'b1);
        write_entry(5'd2, 32'h100, 32'hC, 1'b1, 1'b1);
        check_eq("t1_head_ready", sq_if.head_ready, 64'd1);
        lookup(5'd3, 32'h100);
        check_eq("t1_resp_valid", sq_if.lw_resp_valid, 64'd1);
        check_eq("t1_hit", sq_if.lw_hit, 64'd1);
        check_eq("t1_stall", sq_if.lw_stall, 64'd0);
        check_eq("t1_data", sq_if.lw_data, 64'hC);
        tick();
        check_eq("t1_resp_pulse", sq_if.lw_resp_valid, 64'd0);
        lookup(5'd3, 32'h103);
        check_eq("t1_offset_data", sq_if.lw_data, 64'hC);
        lookup(5'd2, 32'h200);
        check_eq("t1_e2_data", sq_if.lw_data, 64'hB);
        lookup(5'd3, 32'h300);
        check_eq("t1_miss_hit", sq_if.lw_hit, 64'd0);
        check_eq("t1_miss_stall", sq_if.lw_stall, 64'd0);

        // Stall on a missing address, then back-to-back lookups
        do_reset();
        issue_n(3);
        write_entry(5'd0, 32'h100, 32'hA, 1'b1, 1'b1);
        write_entry(5'd1, 32'h200, 32'hB, 1'b0, 1'b1);
        write_entry(5'd2, 32'h100, 32'hC, 1'b1, 1'b1);
        lookup(5'd3, 32'h100);
        check_eq("t2_stall", sq_if.lw_stall, 64'd1);
        check_eq("t2_stall_hit", sq_if.lw_hit, 64'd0);
        lookup(5'd1, 32'h100);
        check_eq("t2_e1_hit", sq_if.lw_hit, 64'd1);
        check_eq("t2_e1_data", sq_if.lw_data, 64'hA);
        write_entry(5'd1, 32'h200, 32'hB, 1'b1, 1'b0);
        sq_if.lw_req_valid = 1'b1;
        sq_if.lw_entry     = 5'd3;
        sq_if.lw_addr      = 32'h100;
        tick();
        sq_if.lw_entry     = 5'd1;
        check_eq("t2_b2b_first", sq_if.lw_data, 64'hC);
        tick();
        sq_if.lw_req_valid = 1'b0;
        check_eq("t2_b2b_valid", sq_if.lw_resp_valid, 64'd1);
        check_eq("t2_b2b_second", sq_if.lw_data, 64'hA);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 30; i++) begin
            issue_n(1);
            write_entry(5'(i), 32'h0, 32'(i), 1'b1, 1'b1);
            commit_one();
        end
        check_eq("t3_commit_ptr", sq_if.commit_ptr, 64'd30);
        check_eq("t3_empty", sq_if.empty, 64'd1);
        issue_n(4);
        check_eq("t3_issue_ptr", sq_if.issue_ptr, 64'd2);
        for (int i = 0; i < 4; i++) begin
            write_entry(5'(30 + i), 32'h40, 32'((30 + i) % 32), 1'b1, 1'b1);
        end
        lookup(5'd1, 32'h40);
        check_eq("t3_wrap_hit", sq_if.lw_hit, 64'd1);
        check_eq("t3_wrap_data", sq_if.lw_data, 64'd0);
        lookup(5'd30, 32'h40);
        check_eq("t3_head_miss_hit", sq_if.lw_hit, 64'd0);
        check_eq("t3_head_miss_stall", sq_if.lw_stall, 64'd0);

        // Full queue
        do_reset();
        issue_n(32);
        check_eq("t4_full", sq_if.full, 64'd1);
        check_eq("t4_issue_ptr", sq_if.issue_ptr, 64'd0);
        issue_n(1);
        check_eq("t4_extra_ptr", sq_if.issue_ptr, 64'd0);
        check_eq("t4_extra_full", sq_if.full, 64'd1);
        for (int e = 0; e < 32; e++) begin
            write_entry(5'(e), 32'h1000 + 32'(e) * 32'd16, 32'h100 + 32'(e), 1'b1, 1'b1);
        end
        lookup(5'd0, 32'h11F0);
        check_eq("t4_all_older_hit", sq_if.lw_hit, 64'd1);
        check_eq("t4_all_older_data", sq_if.lw_data, 64'h11F);
        sq_if.commit_valid = 1'b1;
        sq_if.issue_valid  = 1'b1;
        tick();
        sq_if.commit_valid = 1'b0;
        sq_if.issue_valid  = 1'b0;
        check_eq("t4_ci_commit_ptr", sq_if.commit_ptr, 64'd1);
        check_eq("t4_ci_issue_ptr", sq_if.issue_ptr, 64'd1);
        check_eq("t4_ci_full", sq_if.full, 64'd1);
        check_eq("t4_ci_mem_we", sq_if.mem_we, 64'd1);
        check_eq("t4_ci_mem_addr", sq_if.mem_addr, 64'h1000);
        check_eq("t4_ci_mem_data", sq_if.mem_data, 64'h100);
        do_reset();
        check_eq("t4_rst_full", sq_if.full, 64'd0);
        check_eq("t4_rst_empty", sq_if.empty, 64'd1);

        // Commit gated on missing data
        issue_n(1);
        write_entry(5'd0, 32'h300, 32'h0, 1'b1, 1'b0);
        check_eq("t5_not_ready", sq_if.head_ready, 64'd0);
        commit_one();
        check_eq("t5_no_mem_we", sq_if.mem_we, 64'd0);
        check_eq("t5_ptr_held", sq_if.commit_ptr, 64'd0);
        write_entry(5'd0, 32'h300, 32'hDD, 1'b0, 1'b1);
        check_eq("t5_ready", sq_if.head_ready, 64'd1);
        sq_if.st_data_valid = 1'b1;
        sq_if.st_data_entry = 5'd0;
        sq_if.st_data       = 32'hEE;
        commit_one();
        sq_if.st_data_valid = 1'b0;
        check_eq("t5_mem_we", sq_if.mem_we, 64'd1);
        check_eq("t5_mem_addr", sq_if.mem_addr, 64'h300);
        check_eq("t5_mem_data", sq_if.mem_data, 64'hDD);
        check_eq("t5_empty", sq_if.empty, 64'd1);
        tick();
        check_eq("t5_mem_pulse", sq_if.mem_we, 64'd0);

        // Flush with pending entries and a concurrent issue
        do_reset();
        issue_n(5);
        write_entry(5'd0, 32'h100, 32'h55, 1'b1, 1'b1);
        sq_if.issue_valid  = 1'b1;
        sq_if.flush        = 1'b1;
        sq_if.lw_req_valid = 1'b1;
        sq_if.lw_entry     = 5'd5;
        sq_if.lw_addr      = 32'h100;
        tick();
        sq_if.issue_valid  = 1'b0;
        sq_if.flush        = 1'b0;
        sq_if.lw_req_valid = 1'b0;
        check_eq("t6_empty", sq_if.empty, 64'd1);
        check_eq("t6_issue_ptr", sq_if.issue_ptr, 64'd0);
        check_eq("t6_commit_ptr", sq_if.commit_ptr, 64'd0);
        check_eq("t6_flush_resp", sq_if.lw_resp_valid, 64'd0);
        lookup(5'd5, 32'h100);
        check_eq("t6_post_valid", sq_if.lw_resp_valid, 64'd1);
        check_eq("t6_post_hit", sq_if.lw_hit, 64'd0);
        check_eq("t6_post_stall", sq_if.lw_stall, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
